// File: rtl/soc_gpio_bridge_pkg.sv
// Shared types and constants for the SoC GPIO bridge and its local register block.
package soc_gpio_bridge_pkg;

    // Bridge transaction state.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    // Local register window, indexed by addr[3:2] (byte offsets 0x0, 0x4, 0x8, 0xC).
    typedef enum logic [1:0] {
        REG_IRQ_RAW  = 2'd0,
        REG_IRQ_MASK = 2'd1,
        REG_IRQ_PEND = 2'd2,
        REG_TO_COUNT = 2'd3
    } local_reg_e;

    // Channel number that selects the local register window instead of a slave.
    localparam logic [3:0] LOCAL_CH = 4'hF;

    // Highest valid word index inside a slave window (offsets 0x00..0x24).
    localparam logic [3:0] SLAVE_WORD_MAX = 4'h9;

    // Width of the BUSY watchdog timer; covers TIMEOUT up to 65535.
    localparam int unsigned TIMER_W = 16;

endpackage

// File: rtl/soc_gpio_irq_regs.sv
// Local register block: interrupt RAW/MASK/PEND, saturating timeout counter
// and the registered aggregated interrupt line.
module soc_gpio_irq_regs
    import soc_gpio_bridge_pkg::*;
#(
    parameter int unsigned NCH = 7,
    parameter int unsigned DW  = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NCH-1:0] inta_i,
    input  logic           wr_en_i,
    input  local_reg_e     idx_i,
    input  logic [NCH-1:0] wr_data_i,
    input  logic           timeout_i,
    output logic [DW-1:0]  rd_data_o,
    output logic           inta_o
);

    logic [NCH-1:0] raw_q;
    logic [NCH-1:0] mask_q, mask_d;
    logic [7:0]     to_count_q, to_count_d;
    logic           inta_q;

    // Next state of the mask and of the saturating timeout counter.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        mask_d     = mask_q;
        to_count_d = to_count_q;
        if (wr_en_i && idx_i == REG_IRQ_MASK) begin
            mask_d = wr_data_i;
        end
        if (wr_en_i && idx_i == REG_TO_COUNT) begin
            to_count_d = '0;
        end else if (timeout_i && to_count_q != 8'hFF) begin
            to_count_d = to_count_q + 8'd1;
        end
    end

    // Register the interrupt inputs, the mask, the counter and the aggregated line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raw_q      <= '0;
            mask_q     <= '1;
            to_count_q <= '0;
            inta_q     <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            raw_q      <= inta_i;
            mask_q     <= mask_d;
            to_count_q <= to_count_d;
            inta_q     <= |(raw_q & mask_q);
        end
    end

    // Read multiplexer; narrower registers are zero-extended.
    always_comb begin
        rd_data_o = '0;
        unique case (idx_i)
            REG_IRQ_RAW:  rd_data_o[NCH-1:0] = raw_q;
            REG_IRQ_MASK: rd_data_o[NCH-1:0] = mask_q;
            REG_IRQ_PEND: rd_data_o[NCH-1:0] = raw_q & mask_q;
            REG_TO_COUNT: rd_data_o[7:0]     = to_count_q;
            default:      rd_data_o          = '0;
        endcase
    end

    assign inta_o = inta_q;

endmodule

// File: rtl/soc_gpio_bridge.sv
// Wishbone bridge fanning one SoC slave port out to NCH GPIO slaves, with a
// local interrupt/status window at channel 0xF and a BUSY watchdog.
module soc_gpio_bridge
    import soc_gpio_bridge_pkg::*;
#(
    parameter int unsigned   NCH          = 7,
    parameter int unsigned   DW           = 32,
    parameter int unsigned   TIMEOUT      = 255,
    parameter bit            UNMAPPED_ERR = 1'b0,
    parameter logic [DW-1:0] DEFAULT_DATA = 32'h1bad_c0de
) (
    input  logic              gpio_clk_i,
    input  logic              gpio_rst_i,
    input  logic [DW-1:0]     gpio_data_i,
    output logic [DW-1:0]     gpio_data_o,
    input  logic [31:0]       gpio_addr_i,
    input  logic [3:0]        gpio_sel_i,
    input  logic              gpio_we_i,
    input  logic              gpio_cyc_i,
    input  logic              gpio_stb_i,
    output logic              gpio_ack_o,
    output logic              gpio_err_o,
    output logic              gpio_rty_o,
    output logic [NCH-1:0]    sl_cyc_o,
    output logic [NCH-1:0]    sl_stb_o,
    output logic [7:0]        sl_adr_o,
    output logic [DW-1:0]     sl_dat_o,
    output logic [3:0]        sl_sel_o,
    output logic              sl_we_o,
    input  logic [NCH*DW-1:0] sl_dat_i,
    input  logic [NCH-1:0]    sl_ack_i,
    input  logic [NCH-1:0]    sl_err_i,
    input  logic [NCH-1:0]    sl_inta_i,
    output logic              gpio_inta_o
);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           ch_q, ch_d;
    logic [7:0]           adr_q, adr_d;
    logic [DW-1:0]        wdat_q, wdat_d;
    logic [3:0]           sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [DW-1:0]        rdat_q, rdat_d;

    logic                 req;
    logic                 is_mapped;
    logic                 is_local;
    logic                 irq_wr_en;
    logic                 timeout_hit;
    logic [DW-1:0]        irq_rd_data;
    logic [NCH-1:0]       ch_strobe;
    logic                 slave_ack;
    logic                 slave_err;
    logic [DW-1:0]        slave_rdata;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{gpio_addr_i[31:28], gpio_addr_i[1:0]};

    // Address decode of the live request (only meaningful while IDLE).
    assign req       = gpio_cyc_i && gpio_stb_i;
    assign is_mapped = (gpio_addr_i[27:24] < 4'(NCH))
                    && (gpio_addr_i[23:6] == '0)
                    && (gpio_addr_i[5:2] <= SLAVE_WORD_MAX);
    assign is_local  = (gpio_addr_i[27:24] == LOCAL_CH) && (gpio_addr_i[23:4] == '0);

    // Per-channel strobes come from the latched channel, never the live address.
    always_comb begin
        ch_strobe   = '0;
        slave_ack   = 1'b0;
        slave_err   = 1'b0;
        slave_rdata = '0;
        for (int n = 0; n < int'(NCH); n++) begin
            if (ch_q == 4'(n)) begin
                ch_strobe[n] = (state_q == ST_BUSY);
                slave_ack    = sl_ack_i[n];
                slave_err    = sl_err_i[n];
                slave_rdata  = sl_dat_i[n*DW +: DW];
            end
        end
    end

    // Bridge FSM next-state, request latch and registered termination.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ch_d        = ch_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdat_d      = rdat_q;
        irq_wr_en   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (is_mapped) begin
                        state_d = ST_BUSY;
                        timer_d = '0;
                        ch_d    = gpio_addr_i[27:24];
                        adr_d   = gpio_addr_i[7:0];
                        wdat_d  = gpio_data_i;
                        sel_d   = gpio_sel_i;
                        we_d    = gpio_we_i;
                    end else if (is_local) begin
                        state_d   = ST_RESP;
                        ack_d     = 1'b1;
                        rdat_d    = irq_rd_data;
                        irq_wr_en = gpio_we_i;
                    end else if (UNMAPPED_ERR) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        rdat_d  = DEFAULT_DATA;
                    end
                end
            end
            ST_BUSY: begin
                // A master that drops cyc abandons the access; nothing is returned.
                if (!gpio_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (slave_ack) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    rdat_d  = slave_rdata;
                end else if (slave_err) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    err_d       = 1'b1;
                    timeout_hit = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered master outputs.
    always_ff @(posedge gpio_clk_i or posedge gpio_rst_i) begin
        if (gpio_rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            ch_q    <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ch_q    <= ch_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    soc_gpio_irq_regs #(
        .NCH (NCH),
        .DW  (DW)
    ) u_irq_regs (
        .clk_i     (gpio_clk_i),
        .rst_i     (gpio_rst_i),
        .inta_i    (sl_inta_i),
        .wr_en_i   (irq_wr_en),
        .idx_i     (local_reg_e'(gpio_addr_i[3:2])),
        .wr_data_i (gpio_data_i[NCH-1:0]),
        .timeout_i (timeout_hit),
        .rd_data_o (irq_rd_data),
        .inta_o    (gpio_inta_o)
    );

    assign gpio_data_o = rdat_q;
    assign gpio_ack_o  = ack_q;
    assign gpio_err_o  = err_q;
    assign gpio_rty_o  = 1'b0;
    assign sl_cyc_o    = ch_strobe;
    assign sl_stb_o    = ch_strobe;
    assign sl_adr_o    = adr_q;
    assign sl_dat_o    = wdat_q;
    assign sl_sel_o    = sel_q;
    assign sl_we_o     = we_q;

endmodule

// File: doc/soc_gpio_bridge.md
# soc_gpio_bridge

Parametrised Wishbone bridge placing up to 15 GPIO-class slaves behind one SoC slave port. It decodes `addr[27:24]` to a channel and forwards the access through a registered state machine. Each access is closed with `ack` or `err`, and a bus-timeout watchdog terminates accesses to silent slaves. A local register window at channel `4'hF` aggregates and masks the slave interrupts into one line.

## Interface
- `NCH`, 7: number of slave channels, 1..15; channel `4'hF` is reserved for local registers.
- `DW`, 32: data width.
- `TIMEOUT`, 255: cycles in BUSY without a slave response before `err`; range 2..65535.
- `UNMAPPED_ERR`, 0: 0 = unmapped access gets `ack` with `DEFAULT_DATA`; 1 = unmapped access gets `err`.
- `DEFAULT_DATA`, `32'h1bad_c0de`: read data returned for an unmapped `ack`.

Ports:
- `gpio_clk_i` in 1: clock.
- `gpio_rst_i` in 1: reset, asynchronous, active-high.
- `gpio_data_i` in DW: master write data.
- `gpio_data_o` out DW: master read data, registered.
- `gpio_addr_i` in 32: address; `[27:24]` channel, `[7:0]` slave offset.
- `gpio_sel_i` in 4: byte selects.
- `gpio_we_i`, `gpio_cyc_i`, `gpio_stb_i` in 1 each: Wishbone classic controls.
- `gpio_ack_o`, `gpio_err_o` out 1 each: registered termination.
- `gpio_rty_o` out 1: tied 0.
- `sl_cyc_o`, `sl_stb_o` out NCH each: one-hot per-channel strobes.
- `sl_adr_o` out 8: `addr[7:0]` of the latched request.
- `sl_dat_o` out DW, `sl_sel_o` out 4, `sl_we_o` out 1: latched request fields.
- `sl_dat_i` in NCH*DW: slave read data; channel n occupies `[n*DW +: DW]`.
- `sl_ack_i`, `sl_err_i`, `sl_inta_i` in NCH each: per-slave responses and interrupts.
- `gpio_inta_o` out 1: aggregated masked interrupt, registered.

## Operation
- Request latch: address, data, sel and we are captured on IDLE→BUSY and are not tracked after that.
- Mapped slave access:
  - `addr[27:24] < NCH`;
  - `addr[23:6] == 0`;
  - `addr[5:2] <= 4'h9` (offsets 0x00–0x24).
- Local access: `addr[27:24] == 4'hF`, `addr[23:4] == 0`. Local registers:
  - 0x0: IRQ_RAW, RO, synchronised `sl_inta_i`.
  - 0x4: IRQ_MASK, RW; reset value all ones, width NCH, upper bits read 0.
  - 0x8: IRQ_PEND, RO, = RAW & MASK.
  - 0xC: TO_COUNT, RO, 8-bit saturating timeout count; any write clears it.
- Any other address is unmapped.
- FSM:
  - **IDLE**:
    - cyc&stb to a mapped slave → BUSY, timer cleared.
    - cyc&stb to local or unmapped → RESP; local writes take effect on this edge.
  - **BUSY**:
    - `sl_cyc_o[ch]` and `sl_stb_o[ch]` are high, decoded from state (not from the live address).
    - `sl_ack_i[ch]` → RESP with ack and `sl_dat_i[ch]`.
    - Else `sl_err_i[ch]` → RESP with err.
    - Else timer == TIMEOUT-1 → RESP with err; TO_COUNT increments, saturating at 0xFF.
    - `gpio_cyc_i` low → IDLE, no termination (abort).
  - **RESP**: exactly one of ack/err is high for one cycle → IDLE.
- Simultaneous events:
  - Slave ack and timeout on the same cycle: ack wins.
  - Slave ack and err on the same cycle: ack wins.
  - Write clearing TO_COUNT cannot coincide with a timeout, because local accesses never overlap BUSY.
- Interrupt path: `sl_inta_i` is registered into RAW; `gpio_inta_o <= |(RAW & MASK)`. A mask write affects `gpio_inta_o` two edges later.
- Reset (any time, including mid-access):
  - state → IDLE;
  - all outputs 0;
  - RAW 0, MASK all ones, TO_COUNT 0, timer 0.

## Timing
- Master `ack`/`err` is registered; `gpio_data_o` is valid only in the RESP cycle and holds its value otherwise.
- Local/unmapped access: stb sampled at edge 0, ack/err high in cycle 1.
- Slave access: stb at edge 0, slave strobes high in cycle 1. A slave acking at edge k+1 gives master ack in cycle k+2; for gpio_top (k=1) this is master ack in cycle 3.
- Slave strobes drop in the RESP cycle, so the slave sees no back-to-back strobe.
- Minimum spacing: 2 cycles between local accesses; 4 cycles between gpio_top accesses.
- Timeout: err in cycle TIMEOUT+1 after the stb sample.

## Structure
- Package `soc_gpio_bridge_pkg`:
  - state enum (IDLE/BUSY/RESP);
  - local offsets;
  - `LOCAL_CH = 4'hF`;
  - offset-range constant 4'h9.
- Sub-module `soc_gpio_irq_regs` holds RAW/MASK/TO_COUNT and the inta aggregation; the bridge FSM stays in the top level.

## Test plan
- Read ch2 offset 0x00 with a gpio_top model acking 1 cycle after strobe → `sl_stb_o == 3'b100`-pattern in cycle 1, master ack in cycle 3, data = model value.
- Read `0x0700_0000` with NCH=7 → UNMAPPED_ERR=0: ack in cycle 1, data `32'h1bad_c0de`; UNMAPPED_ERR=1: err in cycle 1.
- Silent slave, TIMEOUT=4 → err in cycle 5, TO_COUNT reads 1; write 0xC → reads 0.
- `sl_inta_i[5]=1`, MASK=0x7F → `gpio_inta_o` high two edges later; write MASK=0x5F → low two edges after the write ack.
- Drop `gpio_cyc_i` in BUSY → slave strobes low next cycle, no ack/err; assert reset in BUSY → all outputs 0 immediately, MASK reads 0x7F.
